pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter stage directly upstream of the PC address decoder. Holds the architectural PC
//  and computes the next PC (sequential / branch / jump), honouring pipeline stalls. Drives the
//  decoder's 32-bit address input and consumes the decoder's invalid-PC flag, freezing fetch in a
//  fault state until software/host clears it. Sits between branch resolution and instruction ROM.
// PARAMETERS
//  RESET_VEC   32'h0040_0000  PC loaded on reset (base of instruction memory window)
//  FAULT_VEC   32'h0040_0180  PC loaded when a fault is cleared (exception handler entry)
//  PC_W        32             PC width; all PC arithmetic modulo 2**PC_W
// PORTS
//  clk            in   1      system clock, all state updates on rising edge
//  rst_n          in   1      synchronous, active-low reset
//  stall          in   1      hold PC this cycle (downstream not ready)
//  jump           in   1      redirect to jump_target (priority over branch)
//  jump_target    in   PC_W   jump destination
//  branch_taken   in   1      redirect to branch_target
//  branch_target  in   PC_W   branch destination
//  pc_invalid     in   1      decoder flag: current pc is outside instruction memory
//  fault_clr      in   1      acknowledge fault, restart at FAULT_VEC
//  pc             out  PC_W   current PC, to decoder address input
//  pc_plus4       out  PC_W   pc + 4 (combinational, wraps), for link/branch calc
//  pc_valid       out  1      pc is a live fetch address this cycle
//  fetch_fault    out  1      sticky fault indicator
//  fault_addr     out  PC_W   PC captured when fault raised
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_VEC, pc_valid=0, fetch_fault=0, fault_addr=0, state=BOOT,
//   pending redirect cleared. Reset wins over every other input, including mid-stall/mid-fault.
//  FSM states BOOT, RUN, FAULT:
//   BOOT : pc_valid=0, pc held; unconditionally -> RUN next cycle (pc_valid=1 one cycle after reset release).
//   RUN  : pc_valid=1. Per edge, priority high->low:
//          1) pc_invalid=1 -> FAULT; fault_addr<=pc; fetch_fault<=1; pc held; pending cleared.
//          2) stall=1 -> pc held; any jump/branch this cycle captured in pending register
//             (jump beats branch; newer redirect overwrites older pending).
//          3) jump=1 -> pc<=jump_target; 4) branch_taken=1 -> pc<=branch_target;
//          5) pending valid -> pc<=pending target, pending cleared; 6) else pc<=pc+4.
//          Live redirect in the unstall cycle beats the pending one (pending discarded).
//   FAULT: pc_valid=0, pc and fault_addr held, stall/jump/branch ignored. fault_clr=1 ->
//          pc<=FAULT_VEC, fetch_fault<=0, -> BOOT. fault_addr retains value until next fault.
//  pc_invalid sampled only when state=RUN; ignored in BOOT/FAULT.
//  pc+4 wraps at 2**PC_W (32'hFFFF_FFFC -> 0); no saturation. Targets used verbatim (no masking).
//  Latency: redirect asserted in cycle N appears on pc in cycle N+1 (no stall).
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined: in RUN, pc[1:0]!=0 is treated exactly as pc_invalid=1 (same
//   priority, fault_addr=pc). Extra output fault_misaligned (1 bit, reset 0) set with the fault
//   when cause was alignment only, cleared by fault_clr.
//  Not defined: pc[1:0] unchecked; misalignment reported only via decoder's pc_invalid; port absent.
// STRUCTURE
//  Shared package fetch_pkg: state encoding (BOOT/RUN/FAULT), RESET_VEC/FAULT_VEC defaults,
//   PC_W, redirect-select encoding.
//  One sub-module: pc_next_mux (combinational next-PC select: jump/branch/pending/seq/hold).
//  Pending redirect register (valid + target) and FSM live in pc_fetch_unit.
// TESTING
//  T1 reset then 4 free-run cycles -> pc 00400000 (pc_valid=0), 00400000, 00400004, 00400008.
//  T2 jump=1 target 00400100 with branch_taken=1 target 00400200 same cycle -> pc=00400100 next.
//  T3 stall 3 cycles at pc=00400010, branch 00400040 in stall cycle 2 -> pc holds 00400010,
//     then 00400040 on first unstalled edge, then 00400044.
//  T4 jump to 00401000, pc_invalid=1 -> fetch_fault=1, fault_addr=00401000, pc_valid=0; inputs
//     ignored 5 cycles; fault_clr -> pc=00400180, BOOT, then RUN with pc_valid=1.
//  T5 pc=FFFFFFFC (pc_invalid forced 0) -> next pc=00000000, pc_plus4 wraps correctly.
//  T6 rst_n=0 during FAULT and during stall with pending -> all outputs at reset values, no
//     pending redirect applied afterwards; with PC_ALIGN_CHECK_EN jump to 00400002 -> fault,
//     fault_misaligned=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: FSM state encoding, vectors, next-PC select codes.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional build macro PC_ALIGN_CHECK_EN is consumed by pc_fetch_unit.
package fetch_pkg;

  localparam int DEF_PC_W = 32;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [DEF_PC_W-1:0] DEF_FAULT_VEC = 32'h0040_0180;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_PEND   = 3'd3,
    SEL_SEQ    = 3'd4
  } next_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select while running: hold / jump / branch / pending / sequential.
// Latency: zero (pure combinational). Backpressure: stall forces hold.
// Sequential increment wraps modulo 2**PC_W; targets pass through unmasked.
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            pend_vld,
  input  logic [PC_W-1:0] pend_target,
  input  logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] next_pc
);

  next_sel_t sel;

  always_comb begin
    sel = SEL_SEQ;
    if (stall)             sel = SEL_HOLD;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (pend_vld)     sel = SEL_PEND;
  end

  always_comb begin
    next_pc = pc + PC_W'(4);
    case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_JUMP:   next_pc = jump_target;
      SEL_BRANCH: next_pc = branch_target;
      SEL_PEND:   next_pc = pend_target;
      default:    next_pc = pc + PC_W'(4);
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter stage with BOOT/RUN/FAULT FSM; PC_ALIGN_CHECK_EN adds misalignment faults.
// Latency: redirect in cycle N shows on pc in cycle N+1; pc_valid rises one cycle after reset release.
// Backpressure: stall holds pc and parks any redirect in a single pending slot until release.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [PC_W-1:0] FAULT_VEC = DEF_FAULT_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            pc_invalid,
  input  logic            fault_clr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            fetch_fault,
  output logic [PC_W-1:0] fault_addr
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic            fault_misaligned
`endif
);

  fetch_state_t    state;
  logic            pend_vld;
  logic [PC_W-1:0] pend_target;
  logic [PC_W-1:0] next_pc;
  logic            fault_cond;

  assign pc_plus4 = pc + PC_W'(4);

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |pc[1:0];
  assign fault_cond = pc_invalid | misaligned;
`else
  assign fault_cond = pc_invalid;
`endif

  pc_next_mux #(.PC_W(PC_W)) u_next (
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pend_vld      (pend_vld),
    .pend_target   (pend_target),
    .pc            (pc),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      pc_valid    <= 1'b0;
      fetch_fault <= 1'b0;
      fault_addr  <= '0;
      pend_vld    <= 1'b0;
      pend_target <= '0;
`ifdef PC_ALIGN_CHECK_EN
      fault_misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (fault_cond) begin
            state       <= ST_FAULT;
            pc_valid    <= 1'b0;
            fetch_fault <= 1'b1;
            fault_addr  <= pc;
            pend_vld    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_misaligned <= misaligned & ~pc_invalid;
`endif
          end else begin
            pc <= next_pc;
            // A pending redirect survives only while stalled; release consumes or discards it.
            if (stall) begin
              if (jump) begin
                pend_vld    <= 1'b1;
                pend_target <= jump_target;
              end else if (branch_taken) begin
                pend_vld    <= 1'b1;
                pend_target <= branch_target;
              end
            end else begin
              pend_vld <= 1'b0;
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state       <= ST_BOOT;
            pc          <= FAULT_VEC;
            fetch_fault <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fault_misaligned <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= ST_BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, sequencing, redirects, stalls, faults, wrap, reset priority.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_invalid;
  logic        fault_clr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        fetch_fault;
  logic [31:0] fault_addr;
`ifdef PC_ALIGN_CHECK_EN
  logic        fault_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_invalid    (pc_invalid),
    .fault_clr     (fault_clr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .fetch_fault   (fetch_fault),
    .fault_addr    (fault_addr)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .fault_misaligned (fault_misaligned)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; jump = 0; branch_taken = 0; pc_invalid = 0; fault_clr = 0;
    jump_target = 32'h0; branch_target = 32'h0;
  endtask

  initial begin
    rst_n = 0;
    idle();

    // T1: reset values, then free run
    tick();
    check("t1_rst_pc", pc, 32'h0040_0000);
    check("t1_rst_valid", {31'b0, pc_valid}, 32'd0);
    check("t1_rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("t1_rst_faddr", fault_addr, 32'h0);
    rst_n = 1;
    tick();
    check("t1_boot_pc", pc, 32'h0040_0000);
    check("t1_run_valid", {31'b0, pc_valid}, 32'd1);
    tick();
    check("t1_seq1", pc, 32'h0040_0004);
    tick();
    check("t1_seq2", pc, 32'h0040_0008);
    check("t1_plus4", pc_plus4, 32'h0040_000C);

    // T2: jump beats branch
    jump = 1; jump_target = 32'h0040_0100;
    branch_taken = 1; branch_target = 32'h0040_0200;
    tick();
    idle();
    check("t2_jump_prio", pc, 32'h0040_0100);

    // T3: stall with branch captured mid-stall
    jump = 1; jump_target = 32'h0040_0010;
    tick();
    idle();
    check("t3_setup", pc, 32'h0040_0010);
    stall = 1;
    tick();
    check("t3_stall1", pc, 32'h0040_0010);
    branch_taken = 1; branch_target = 32'h0040_0040;
    tick();
    branch_taken = 0;
    check("t3_stall2", pc, 32'h0040_0010);
    tick();
    check("t3_stall3", pc, 32'h0040_0010);
    stall = 0;
    tick();
    check("t3_pend_apply", pc, 32'h0040_0040);
    tick();
    check("t3_after", pc, 32'h0040_0044);

    // live redirect at release overrides the pending one, which is then dropped
    stall = 1; jump = 1; jump_target = 32'h0040_0800;
    tick();
    check("t3b_hold", pc, 32'h0040_0044);
    stall = 0; jump = 0; branch_taken = 1; branch_target = 32'h0040_0900;
    tick();
    idle();
    check("t3b_live_wins", pc, 32'h0040_0900);
    tick();
    check("t3b_pend_dropped", pc, 32'h0040_0904);

    // T4: fault and recovery
    jump = 1; jump_target = 32'h0040_1000;
    tick();
    idle();
    check("t4_jump", pc, 32'h0040_1000);
    pc_invalid = 1;
    tick();
    pc_invalid = 0;
    check("t4_fault", {31'b0, fetch_fault}, 32'd1);
    check("t4_faddr", fault_addr, 32'h0040_1000);
    check("t4_valid0", {31'b0, pc_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      stall = i[0]; jump = 1; jump_target = 32'h0040_2000;
      branch_taken = 1; branch_target = 32'h0040_3000;
      tick();
      check("t4_ignored_pc", pc, 32'h0040_1000);
    end
    idle();
    check("t4_still_fault", {31'b0, fetch_fault}, 32'd1);
    fault_clr = 1;
    tick();
    fault_clr = 0;
    check("t4_clr_pc", pc, 32'h0040_0180);
    check("t4_clr_fault", {31'b0, fetch_fault}, 32'd0);
    check("t4_boot_valid", {31'b0, pc_valid}, 32'd0);
    pc_invalid = 1;  // in BOOT: must be ignored
    tick();
    pc_invalid = 0;
    check("t4_run_valid", {31'b0, pc_valid}, 32'd1);
    check("t4_boot_inv_ignored", {31'b0, fetch_fault}, 32'd0);
    check("t4_run_pc", pc, 32'h0040_0180);
    tick();
    check("t4_run_seq", pc, 32'h0040_0184);
    check("t4_faddr_kept", fault_addr, 32'h0040_1000);

    // T5: wrap
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    idle();
    check("t5_top", pc, 32'hFFFF_FFFC);
    check("t5_plus4_wrap", pc_plus4, 32'h0000_0000);
    tick();
    check("t5_wrap", pc, 32'h0000_0000);
    check("t5_plus4", pc_plus4, 32'h0000_0004);

    // T6a: reset during FAULT
    pc_invalid = 1;
    tick();
    pc_invalid = 0;
    check("t6_in_fault", {31'b0, fetch_fault}, 32'd1);
    rst_n = 0; fault_clr = 1;
    tick();
    fault_clr = 0;
    check("t6_rst_pc", pc, 32'h0040_0000);
    check("t6_rst_fault", {31'b0, fetch_fault}, 32'd0);
    check("t6_rst_faddr", fault_addr, 32'h0);
    check("t6_rst_valid", {31'b0, pc_valid}, 32'd0);
    rst_n = 1;
    tick();
    tick();
    check("t6_seq", pc, 32'h0040_0004);

    // T6b: reset during stall with a pending redirect
    stall = 1; jump = 1; jump_target = 32'h0040_0700;
    tick();
    check("t6_stall_hold", pc, 32'h0040_0004);
    rst_n = 0;
    idle();
    tick();
    check("t6_rst2_pc", pc, 32'h0040_0000);
    rst_n = 1;
    tick();
    check("t6_boot2_pc", pc, 32'h0040_0000);
    tick();
    check("t6_no_pend", pc, 32'h0040_0004);

`ifdef PC_ALIGN_CHECK_EN
    check("t6_mis_idle", {31'b0, fault_misaligned}, 32'd0);
    jump = 1; jump_target = 32'h0040_0002;
    tick();
    idle();
    check("t6_mis_pc", pc, 32'h0040_0002);
    tick();
    check("t6_mis_fault", {31'b0, fetch_fault}, 32'd1);
    check("t6_mis_flag", {31'b0, fault_misaligned}, 32'd1);
    check("t6_mis_faddr", fault_addr, 32'h0040_0002);
    fault_clr = 1;
    tick();
    fault_clr = 0;
    check("t6_mis_clr", {31'b0, fault_misaligned}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
